// File: rtl/wasm_pkg.sv
// Shared definitions for the wasm loader front end: LEB128 limits, reader
// state encoding and small byte-level helpers used by the decoder datapath.
package wasm_pkg;

    localparam int LEB_MAX_BYTES = 5;
    localparam int ROM_ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } leb_state_e;

    // Payload of byte idx placed at bit 7*idx; the 5th byte only has room for 4 bits.
    function automatic logic [31:0] leb_chunk(input logic [7:0] b, input logic [2:0] idx);
        logic [31:0] r;
        case (idx)
            3'd0:    r = {25'b0, b[6:0]};
            3'd1:    r = {18'b0, b[6:0], 7'b0};
            3'd2:    r = {11'b0, b[6:0], 14'b0};
            3'd3:    r = {4'b0, b[6:0], 21'b0};
            3'd4:    r = {b[3:0], 28'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] leb_sign_extend(input logic [31:0] acc, input logic [2:0] n);
        logic [31:0] r;
        case (n)
            3'd1:    r = {{25{acc[6]}}, acc[6:0]};
            3'd2:    r = {{18{acc[13]}}, acc[13:0]};
            3'd3:    r = {{11{acc[20]}}, acc[20:0]};
            3'd4:    r = {{4{acc[27]}}, acc[27:0]};
            default: r = acc;
        endcase
        return r;
    endfunction

    // Bits [6:4] of a final 5th byte cannot be represented in 32 bits unless they
    // are pure zero-extension (unsigned) or sign-extension of bit 3 (signed).
    function automatic logic leb_bad_last(input logic [7:0] b, input logic sgn);
        logic r;
        if (sgn) r = (b[6:4] != {3{b[3]}});
        else     r = (b[6:4] != 3'b000);
        return r;
    endfunction

endpackage

// File: rtl/leb128_reader_if.sv
// ROM read port between the LEB128 reader (master) and the program ROM (slave).
interface leb128_reader_if;
    import wasm_pkg::*;

    logic [ROM_ADDR_W-1:0] rom_addr;
    logic                  rom_read_en;
    logic [7:0]            rom_data;
    logic                  rom_ready;

    modport master (
        output rom_addr,
        output rom_read_en,
        input  rom_data,
        input  rom_ready
    );

    modport slave (
        input  rom_addr,
        input  rom_read_en,
        output rom_data,
        output rom_ready
    );

endinterface

// File: rtl/leb128_reader.sv
// Fetches bytes from the program ROM and decodes one unsigned or signed LEB128
// value (up to 32 bits) per start request, with a one-byte cache of the last byte.
module leb128_reader
    import wasm_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROM_ADDR_W-1:0] start_addr,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           value,
    output logic [2:0]            len,
    output logic [ROM_ADDR_W-1:0] next_addr,
    output logic                  error,
    leb128_reader_if.master       rom
);

    localparam int               TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(LEB_MAX_BYTES - 1);

    leb_state_e            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [31:0]           value_q, value_d;
    logic [2:0]            len_q, len_d;
    logic [ROM_ADDR_W-1:0] next_addr_q, next_addr_d;
    logic                  error_q, error_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic                  rom_read_en_q, rom_read_en_d;
    logic [ROM_ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic                  signed_q, signed_d;
    logic [31:0]           acc_q, acc_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  hit_q, hit_d;
    logic                  cache_valid_q, cache_valid_d;
    logic [ROM_ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [7:0]            cache_byte_q, cache_byte_d;

    logic                  consume;
    logic [7:0]            byte_sel;
    logic [31:0]           acc_next;
    logic [2:0]            n_next;
    logic                  last_byte;
    logic                  fifth_bad;
    logic [ROM_ADDR_W-1:0] addr_inc;

    // A pending cache hit supplies the first byte without touching the ROM.
    assign byte_sel  = hit_q ? cache_byte_q : rom.rom_data;
    assign consume   = (state_q == FETCH) && (hit_q || rom.rom_ready);
    assign acc_next  = acc_q | leb_chunk(byte_sel, cnt_q);
    assign n_next    = cnt_q + 3'd1;
    assign last_byte = (cnt_q == LAST_IDX);
    assign fifth_bad = byte_sel[7] | leb_bad_last(byte_sel, signed_q);
    assign addr_inc  = cur_addr_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        value_d       = value_q;
        len_d         = len_q;
        next_addr_d   = next_addr_q;
        error_d       = error_q;
        rom_addr_d    = rom_addr_q;
        rom_read_en_d = rom_read_en_q;
        cur_addr_d    = cur_addr_q;
        signed_d      = signed_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        hit_d         = hit_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_byte_d  = cache_byte_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    busy_d     = 1'b1;
                    cur_addr_d = start_addr;
                    signed_d   = signed_mode;
                    acc_d      = '0;
                    cnt_d      = '0;
                    tmo_d      = '0;
                    if (cache_valid_q && (cache_addr_q == start_addr)) begin
                        hit_d = 1'b1;
                    end else begin
                        hit_d         = 1'b0;
                        rom_addr_d    = start_addr;
                        rom_read_en_d = 1'b1;
                    end
                end
            end

            FETCH: begin
                if (consume) begin
                    acc_d         = acc_next;
                    cnt_d         = n_next;
                    cur_addr_d    = addr_inc;
                    tmo_d         = '0;
                    hit_d         = 1'b0;
                    cache_valid_d = 1'b1;
                    cache_addr_d  = cur_addr_q;
                    cache_byte_d  = byte_sel;
                    if (last_byte || !byte_sel[7]) begin
                        state_d       = DONE;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        rom_read_en_d = 1'b0;
                        len_d         = n_next;
                        next_addr_d   = addr_inc;
                        error_d       = last_byte & fifth_bad;
                        value_d       = (signed_q && !last_byte) ?
                                        leb_sign_extend(acc_next, n_next) : acc_next;
                    end else begin
                        rom_addr_d    = addr_inc;
                        rom_read_en_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = DONE;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    rom_read_en_d = 1'b0;
                    len_d         = cnt_q;
                    next_addr_d   = cur_addr_q;
                    error_d       = 1'b1;
                    value_d       = acc_q;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            value_q       <= '0;
            len_q         <= '0;
            next_addr_q   <= '0;
            error_q       <= 1'b0;
            rom_addr_q    <= '0;
            rom_read_en_q <= 1'b0;
            cur_addr_q    <= '0;
            signed_q      <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            hit_q         <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_byte_q  <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            value_q       <= value_d;
            len_q         <= len_d;
            next_addr_q   <= next_addr_d;
            error_q       <= error_d;
            rom_addr_q    <= rom_addr_d;
            rom_read_en_q <= rom_read_en_d;
            cur_addr_q    <= cur_addr_d;
            signed_q      <= signed_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            hit_q         <= hit_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_byte_q  <= cache_byte_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign value           = value_q;
    assign len             = len_q;
    assign next_addr       = next_addr_q;
    assign error           = error_q;
    assign rom.rom_addr    = rom_addr_q;
    assign rom.rom_read_en = rom_read_en_q;

endmodule

// File: tb/tb_leb128_reader.sv
// Testbench for leb128_reader: a quirky ROM model plus directed and random LEB128
// decodes, each compared against an arithmetic reference decoder.
module tb_leb128_reader;
    import wasm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic        signed_mode = 1'b0;
    logic        busy, done, error;
    logic [31:0] value, next_addr;
    logic [2:0]  len;

    int total = 0;
    int bad = 0;

    leb128_reader_if rom_if ();

    leb128_reader #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .value       (value),
        .len         (len),
        .next_addr   (next_addr),
        .error       (error),
        .rom         (rom_if.master)
    );

    always #5 clk = ~clk;

    // ROM model: answers a read one cycle after sampling read_en with an address
    // other than the one it served last; at power-up that is address 0.
    logic [7:0]  mem [0:4095];
    logic [31:0] last_served = '0;
    bit          rom_mute = 1'b0;
    int          read_cnt = 0;

    always @(posedge clk) begin
        rom_if.rom_ready <= 1'b0;
        if (rom_if.rom_read_en === 1'b1 && !rom_mute && rom_if.rom_addr !== last_served) begin
            rom_if.rom_ready <= 1'b1;
            rom_if.rom_data  <= mem[rom_if.rom_addr[11:0]];
            last_served      <= rom_if.rom_addr;
            read_cnt         <= read_cnt + 1;
        end
    end

    // Bench-side view of the one-byte cache: address of the last consumed byte.
    bit          cache_ok = 1'b0;
    logic [31:0] cache_at = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder: accumulate as a wide integer, then range-check the result.
    function automatic void refDecode(input logic [31:0] addr, input bit sgn,
                                      output logic [31:0] val, output int n, output bit err);
        longint      acc;
        logic [7:0]  b;
        logic [31:0] a;
        acc = 0;
        b   = '0;
        n   = 0;
        err = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a   = addr + 32'(k);
            b   = mem[a[11:0]];
            acc = acc + (longint'(b[6:0]) << (7 * k));
            n   = k + 1;
            if (!b[7]) break;
        end
        if (b[7]) begin
            err = 1'b1;
        end else if (n == 5) begin
            if (sgn) begin
                if (acc[34]) acc = acc - (longint'(1) << 35);
                err = (acc < -(longint'(1) << 31)) || (acc > (longint'(1) << 31) - 1);
            end else begin
                err = acc > 64'sh0_FFFF_FFFF;
            end
        end else if (sgn && acc[7 * n - 1]) begin
            acc = acc - (longint'(1) << (7 * n));
        end
        val = acc[31:0];
    endfunction

    task automatic putULeb(input logic [31:0] addr, input logic [31:0] v);
        logic [31:0] a;
        logic [7:0]  b;
        a = addr;
        forever begin
            b = {1'b0, v[6:0]};
            v = v >> 7;
            if (v != 0) b[7] = 1'b1;
            mem[a[11:0]] = b;
            a = a + 32'd1;
            if (v == 0) break;
        end
    endtask

    task automatic putSLeb(input logic [31:0] addr, input int v);
        logic [31:0] a;
        logic [7:0]  b;
        bit          fin;
        a = addr;
        forever begin
            b   = {1'b0, v[6:0]};
            v   = v >>> 7;
            fin = (v == 0 && !b[6]) || (v == -1 && b[6]);
            if (!fin) b[7] = 1'b1;
            mem[a[11:0]] = b;
            a = a + 32'd1;
            if (fin) break;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input bit sgn);
        @(negedge clk);
        start_addr  = addr;
        signed_mode = sgn;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Counts edges after the accepting edge until done is seen; optionally pokes
    // start while busy, which must be ignored.
    task automatic waitDone(input bit poke, output int edges, output bit saw_rd);
        edges  = 0;
        saw_rd = (rom_if.rom_read_en === 1'b1);
        for (int k = 1; k <= 60; k++) begin
            if (poke && k == 1) begin
                start_addr = 32'h0000_0FF0;
                start      = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rom_if.rom_read_en === 1'b1) saw_rd = 1'b1;
            if (done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic doDecode(input string tag, input logic [31:0] addr, input bit sgn, input bit poke);
        logic [31:0] ev;
        int          en, edges, exp_edges;
        bit          eerr, hit, saw_rd;
        refDecode(addr, sgn, ev, en, eerr);
        hit       = cache_ok && (cache_at == addr);
        exp_edges = hit ? 2 * en - 1 : 2 * en;
        applyStimulus(addr, sgn);
        waitDone(poke, edges, saw_rd);
        checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_edges));
        checkOutput({tag, "_len"}, 32'(len), 32'(en));
        checkOutput({tag, "_next_addr"}, next_addr, addr + 32'(en));
        checkOutput({tag, "_error"}, 32'(error), 32'(eerr));
        checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
        if (!eerr) checkOutput({tag, "_value"}, value, ev);
        if (hit && en == 1) checkOutput({tag, "_no_rom_read"}, 32'(saw_rd), 32'd0);
        cache_ok = 1'b1;
        cache_at = addr + 32'(en) - 32'd1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    task automatic doTimeout(input string tag, input logic [31:0] addr);
        int edges;
        bit saw_rd;
        applyStimulus(addr, 1'b0);
        waitDone(1'b0, edges, saw_rd);
        checkOutput({tag, "_latency"}, 32'(edges), 32'd16);
        checkOutput({tag, "_error"}, 32'(error), 32'd1);
        checkOutput({tag, "_len"}, 32'(len), 32'd0);
        checkOutput({tag, "_next_addr"}, next_addr, addr);
        checkOutput({tag, "_read_en_low"}, 32'(rom_if.rom_read_en), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          rc0;
        logic [31:0] base, v;
        bit          sgn;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h10] = 8'hE5; mem[12'h11] = 8'h8E; mem[12'h12] = 8'h26;
        mem[12'h20] = 8'h7F;
        for (int i = 0; i < 4; i++) begin
            mem[12'h30 + 12'(i)] = 8'hFF;
            mem[12'h38 + 12'(i)] = 8'hFF;
        end
        mem[12'h34] = 8'h0F;
        mem[12'h3C] = 8'h1F;
        mem[12'h40] = 8'h05;
        for (int i = 0; i < 6; i++) mem[12'h50 + 12'(i)] = 8'h80;
        mem[12'h70] = 8'hAC; mem[12'h71] = 8'h02;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_read_en", 32'(rom_if.rom_read_en), 32'd0);
        checkOutput("rst_value", value, 32'd0);
        checkOutput("rst_len", 32'(len), 32'd0);
        checkOutput("rst_next_addr", next_addr, 32'd0);
        checkOutput("rst_rom_addr", rom_if.rom_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        doTimeout("powerup_addr0", 32'h0);

        doDecode("u3", 32'h10, 1'b0, 1'b1);
        checkOutput("u3_const", value, 32'h0009_8765);

        doDecode("s1", 32'h20, 1'b1, 1'b0);
        checkOutput("s1_const", value, 32'hFFFF_FFFF);
        doDecode("u1_hit", 32'h20, 1'b0, 1'b0);
        checkOutput("u1_hit_const", value, 32'h0000_007F);

        doDecode("u5", 32'h30, 1'b0, 1'b0);
        checkOutput("u5_const", value, 32'hFFFF_FFFF);
        doDecode("u5_bad", 32'h38, 1'b0, 1'b0);

        doDecode("c_first", 32'h40, 1'b0, 1'b0);
        doDecode("c_hit", 32'h40, 1'b0, 1'b0);
        checkOutput("c_hit_const", value, 32'd5);

        rc0 = read_cnt;
        doDecode("overlong", 32'h50, 1'b0, 1'b0);
        checkOutput("overlong_reads", 32'(read_cnt - rc0), 32'd5);

        rom_mute = 1'b1;
        doTimeout("mute", 32'h60);

        applyStimulus(32'h68, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_read_en", 32'(rom_if.rom_read_en), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_rom_addr", rom_if.rom_addr, 32'd0);
        cache_ok = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        rom_mute = 1'b0;
        doDecode("fresh", 32'h70, 1'b0, 1'b0);
        checkOutput("fresh_const", value, 32'd300);

        for (int it = 0; it < 30; it++) begin
            base = 32'h100 + 32'(16 * it);
            sgn  = 1'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    v = $urandom >> $urandom_range(0, 31);
                    putULeb(base, v);
                    sgn = 1'b0;
                end
                1: begin
                    v = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) v = ~v;
                    putSLeb(base, int'(v));
                    sgn = 1'b1;
                end
                default: begin
                    for (int j = 0; j < 6; j++)
                        mem[base[11:0] + 12'(j)] = {($urandom_range(0, 3) != 0), 7'($urandom)};
                end
            endcase
            doDecode("rand", base, sgn, 1'b0);
            if (it % 3 == 0) doDecode("rand_hit", cache_at, 1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
